wishbone_to_ahb: RTL and testbench
==================================

Name: wishbone_to_ahb

Overview:
Bus adapter in the opposite direction to the AHB-to-Wishbone bridge. A Wishbone classic slave port accepts single transfers from a Wishbone-native core or controller, and an AHB-Lite master port drives an AHB-Lite subordinate such as memory or a peripheral. The bridge handles one outstanding transfer at a time and issues only SINGLE, non-locked transfers. It lets AHB-only targets sit behind the processor_ci Wishbone fabric.

Parameters:
ADDR_WIDTH, 32, width of wb_adr and haddr.
DATA_WIDTH, 32, data width; only 32 is supported.
HPROT_VAL, 4'b0011, constant driven on hprot (data access, privileged).

Ports:
clk  input  1  bridge clock, shared by both sides.
rst_n  input  1  reset, asynchronous, active-low.
wb_cyc  input  1  Wishbone cycle valid.
wb_stb  input  1  Wishbone strobe.
wb_we  input  1  1 = write.
wb_wstrb  input  4  byte lane selects.
wb_adr  input  ADDR_WIDTH  byte address.
wb_dat_w  input  32  write data.
wb_dat_r  output  32  read data, valid while wb_ack is high.
wb_ack  output  1  one-cycle transfer completion.
wb_err  output  1  one-cycle error completion; present only with WB2AHB_ERR_EN.
haddr  output  ADDR_WIDTH  AHB address.
htrans  output  2  AHB transfer type; IDLE = 2'b00, NONSEQ = 2'b10.
hwrite  output  1  AHB write.
hsize  output  3  AHB transfer size.
hburst  output  3  constant 3'b000 (SINGLE).
hprot  output  4  constant HPROT_VAL.
hmastlock  output  1  constant 0.
hwdata  output  32  AHB write data.
hrdata  input  32  AHB read data.
hready  input  1  AHB ready.
hresp  input  1  AHB error response.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values: state = IDLE; htrans, haddr, hwrite, hsize, hwdata, wb_dat_r, wb_ack and wb_err all 0.
- FSM states: IDLE, ADDR, DATA, RESP, DISCARD.
- IDLE:
  - Trigger is wb_cyc & wb_stb.
  - On trigger, register address, data, direction and size, then go to ADDR.
  - htrans = IDLE.
- Size and address mapping for reads: hsize = 3'b010 and haddr = {wb_adr[31:2], 2'b00}; wb_wstrb is ignored.
- Size and address mapping for writes:
  - 4'b1111 gives hsize 3'b010, haddr[1:0] = 00.
  - 4'b0011 gives hsize 3'b001, haddr[1:0] = 00.
  - 4'b1100 gives hsize 3'b001, haddr[1:0] = 10.
  - A one-hot strobe on lane k gives hsize 3'b000, haddr[1:0] = k.
  - Any other pattern, including 0000, is illegal. No AHB transfer is issued; go to RESP with the error flag set.
- ADDR:
  - htrans = NONSEQ; haddr, hwrite and hsize are held stable.
  - On hready = 1, go to DATA.
  - Once issued, the transfer is never withdrawn, even if wb_cyc drops.
- DATA:
  - htrans = IDLE; hwdata = the registered wb_dat_w (full word; the subordinate selects lanes).
  - hready = 0 with hresp = 0: wait.
  - hready = 0 with hresp = 1: first cycle of the error response; wait.
  - hready = 1 with hresp = 0: capture hrdata into wb_dat_r for reads, then go to RESP.
  - hready = 1 with hresp = 1: go to RESP with the error flag set.
- RESP: drive wb_ack (or wb_err) high for exactly one cycle, then go to IDLE. wb_dat_r is held until the next capture.
- Latency: with a zero-wait subordinate, trigger sampled at cycle N → NONSEQ at N+1 → data phase N+2 → ack at N+3. Each hready-low cycle adds one cycle.
- Abort: if wb_cyc is low at any sampled edge in ADDR or DATA, mark the transfer discarded.
  - The AHB transfer still completes normally.
  - No wb_ack or wb_err is issued; go through DISCARD (one cycle, no ack) to IDLE.
- The Wishbone master must drop wb_stb in the cycle after wb_ack. The IDLE state does not re-trigger until the cycle after RESP.
- Reset mid-operation: all outputs return to reset values immediately, including htrans = IDLE during a pending data phase.

Optional Feature:
WB2AHB_ERR_EN.
- Defined: the wb_err port exists. AHB error responses and illegal strobes complete with wb_err = 1, wb_ack = 0, and wb_dat_r is unchanged.
- Undefined: the wb_err port is absent. Errors complete with wb_ack = 1 and wb_dat_r = 32'h0 for reads; a write reported as errored is silently dropped.

Test Plan:
1. Word write: wb_adr = 0x0000_0100, wb_wstrb = 1111, wb_dat_w = 0xDEADBEEF, zero-wait subordinate → NONSEQ at N+1 with haddr 0x100, hsize 010, hwrite 1; hwdata 0xDEADBEEF at N+2; wb_ack at N+3 only.
2. Read with 2 wait states: wb_adr = 0x0000_0206 → haddr 0x204, hsize 010; hrdata = 0x12345678 on the third data cycle → wb_dat_r = 0x12345678 with wb_ack at N+5.
3. Byte write: wb_wstrb = 0100, wb_adr = 0x1000_0000 → haddr 0x1000_0002, hsize 000. Halfword write: wb_wstrb = 1100 → haddr[1:0] = 10, hsize 001.
4. Error responses:
   - Two-cycle AHB error (hready 0 / hresp 1, then hready 1 / hresp 1) → wb_err pulse with ERR_EN; wb_ack with wb_dat_r = 0 without it.
   - Illegal strobe 0101 → no NONSEQ on the bus and an error completion at N+1.
5. Abort: drop wb_cyc during ADDR while hready = 0 → NONSEQ is held until hready, the data phase completes, no wb_ack is issued, and the bridge returns to IDLE.
6. Reset: assert rst_n low during DATA → htrans, wb_ack and wb_dat_r are 0 immediately. After release, a new word read completes in 3 cycles.

Source files
------------

// File: rtl/wishbone_to_ahb.sv
// Wishbone classic slave to AHB-Lite master bridge, one outstanding SINGLE transfer.
// Define WB2AHB_ERR_EN to expose wb_err; otherwise errors complete as wb_ack (reads return 0).
module wishbone_to_ahb #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [3:0]            wb_wstrb,
  input  logic [ADDR_WIDTH-1:0] wb_adr,
  input  logic [DATA_WIDTH-1:0] wb_dat_w,
  output logic [DATA_WIDTH-1:0] wb_dat_r,
  output logic                  wb_ack,
`ifdef WB2AHB_ERR_EN
  output logic                  wb_err,
`endif
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [3:0]            hprot,
  output logic                  hmastlock,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DISCARD} state_e;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic [1:0]            htrans_q;
  logic                  hwrite_q;
  logic [2:0]            hsize_q;
  logic [DATA_WIDTH-1:0] hwdata_q;
  logic [DATA_WIDTH-1:0] wb_dat_r_q;
  logic                  wb_ack_q;
  logic                  discard_q;
`ifdef WB2AHB_ERR_EN
  logic                  wb_err_q;
`endif

  logic [2:0] req_size;
  logic [1:0] req_lo;
  logic       req_illegal;
  logic       unused_adr_lo;

  // Low address bits come from the strobe pattern, not from wb_adr.
  assign unused_adr_lo = ^wb_adr[1:0];

  always_comb begin
    req_size    = 3'b010;
    req_lo      = 2'b00;
    req_illegal = 1'b0;
    if (wb_we) begin
      case (wb_wstrb)
        4'b1111: begin req_size = 3'b010; req_lo = 2'b00; end
        4'b0011: begin req_size = 3'b001; req_lo = 2'b00; end
        4'b1100: begin req_size = 3'b001; req_lo = 2'b10; end
        4'b0001: begin req_size = 3'b000; req_lo = 2'b00; end
        4'b0010: begin req_size = 3'b000; req_lo = 2'b01; end
        4'b0100: begin req_size = 3'b000; req_lo = 2'b10; end
        4'b1000: begin req_size = 3'b000; req_lo = 2'b11; end
        default: req_illegal = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      haddr_q    <= '0;
      htrans_q   <= TR_IDLE;
      hwrite_q   <= 1'b0;
      hsize_q    <= '0;
      hwdata_q   <= '0;
      wb_dat_r_q <= '0;
      wb_ack_q   <= 1'b0;
      discard_q  <= 1'b0;
`ifdef WB2AHB_ERR_EN
      wb_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wb_cyc && wb_stb) begin
            hwrite_q  <= wb_we;
            hwdata_q  <= wb_dat_w;
            discard_q <= 1'b0;
            if (req_illegal) begin
              state_q <= S_RESP;
`ifdef WB2AHB_ERR_EN
              wb_err_q <= 1'b1;
`else
              wb_ack_q <= 1'b1;
`endif
            end else begin
              haddr_q  <= {wb_adr[ADDR_WIDTH-1:2], req_lo};
              hsize_q  <= req_size;
              htrans_q <= TR_NONSEQ;
              state_q  <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (!wb_cyc) discard_q <= 1'b1;
          if (hready) begin
            htrans_q <= TR_IDLE;
            state_q  <= S_DATA;
          end
        end
        S_DATA: begin
          if (!wb_cyc) discard_q <= 1'b1;
          if (hready) begin
            // An abort seen on this same edge still suppresses the completion.
            if (discard_q || !wb_cyc) begin
              state_q <= S_DISCARD;
            end else begin
              state_q <= S_RESP;
              if (hresp) begin
`ifdef WB2AHB_ERR_EN
                wb_err_q <= 1'b1;
`else
                wb_ack_q <= 1'b1;
                if (!hwrite_q) wb_dat_r_q <= '0;
`endif
              end else begin
                wb_ack_q <= 1'b1;
                if (!hwrite_q) wb_dat_r_q <= hrdata;
              end
            end
          end
        end
        S_RESP: begin
          wb_ack_q <= 1'b0;
`ifdef WB2AHB_ERR_EN
          wb_err_q <= 1'b0;
`endif
          state_q  <= S_IDLE;
        end
        S_DISCARD: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign haddr     = haddr_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hsize     = hsize_q;
  assign hwdata    = hwdata_q;
  assign hburst    = 3'b000;
  assign hprot     = HPROT_VAL;
  assign hmastlock = 1'b0;
  assign wb_dat_r  = wb_dat_r_q;
  assign wb_ack    = wb_ack_q;
`ifdef WB2AHB_ERR_EN
  assign wb_err    = wb_err_q;
`endif

endmodule

// File: tb/tb_wishbone_to_ahb.sv
// Scoreboard bench for wishbone_to_ahb: stimulus queues expected AHB address phases
// and Wishbone completions; a negedge monitor pops and compares them.
module tb_wishbone_to_ahb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_wstrb;
  logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
  logic        wb_ack;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata, hrdata;
  logic        hready, hresp;
  logic        err_obs;

`ifdef WB2AHB_ERR_EN
  logic wb_err;
  assign err_obs = wb_err;
`else
  assign err_obs = 1'b0;
`endif

  wishbone_to_ahb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HPROT_VAL(4'b0011)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_wstrb(wb_wstrb),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_ack(wb_ack),
`ifdef WB2AHB_ERR_EN
    .wb_err(wb_err),
`endif
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 clk = ~clk;

  int unsigned e = 0;
  always @(posedge clk) e <= e + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wd;
    int unsigned at;
  } ahb_exp_t;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
    int unsigned at;
  } wb_exp_t;

  ahb_exp_t q_ahb[$];
  wb_exp_t  q_wb[$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] model_dat_r = 32'h0;
  logic        done = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, e, act, exp);
    end
  endtask

  ahb_exp_t    ma;
  wb_exp_t     mw;
  logic        pend_wd = 1'b0;
  logic [31:0] pend_val;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend_wd = 1'b0;
      check("rst_htrans", {30'h0, htrans}, 32'h0);
      check("rst_haddr", haddr, 32'h0);
      check("rst_hwrite", {31'h0, hwrite}, 32'h0);
      check("rst_hsize", {29'h0, hsize}, 32'h0);
      check("rst_hwdata", hwdata, 32'h0);
      check("rst_wb_dat_r", wb_dat_r, 32'h0);
      check("rst_wb_ack", {31'h0, wb_ack}, 32'h0);
      check("rst_wb_err", {31'h0, err_obs}, 32'h0);
      check("hburst", {29'h0, hburst}, 32'h0);
      check("hprot", {28'h0, hprot}, 32'h3);
      check("hmastlock", {31'h0, hmastlock}, 32'h0);
    end else begin
      if (pend_wd) begin
        check("hwdata", hwdata, pend_val);
        pend_wd = 1'b0;
      end
      if (htrans == 2'b10 && hready) begin
        if (q_ahb.size() == 0) begin
          check("unexpected_nonseq_addr", haddr, 32'hFFFF_FFFF);
        end else begin
          ma = q_ahb.pop_front();
          check("haddr", haddr, ma.addr);
          check("hwrite", {31'h0, hwrite}, {31'h0, ma.wr});
          check("hsize", {29'h0, hsize}, {29'h0, ma.size});
          check("nonseq_cycle", e, ma.at);
          check("hburst", {29'h0, hburst}, 32'h0);
          if (ma.wr) begin
            pend_wd  = 1'b1;
            pend_val = ma.wd;
          end
        end
      end
      if (wb_ack || err_obs) begin
        if (q_wb.size() == 0) begin
          check("unexpected_completion", {30'h0, wb_ack, err_obs}, 32'h0);
        end else begin
          mw = q_wb.pop_front();
          check("resp_kind", {30'h0, wb_ack, err_obs}, mw.err ? 32'h1 : 32'h2);
          check("wb_dat_r", wb_dat_r, mw.dat);
          check("resp_cycle", e, mw.at);
        end
      end
    end
    if (done) begin
      check("ahb_queue_left", q_ahb.size(), 32'h0);
      check("wb_queue_left", q_wb.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  task automatic txn(input logic we, input logic [31:0] adr, input logic [3:0] strb,
                     input logic [31:0] wd, input int unsigned aw, input int unsigned dw,
                     input logic [31:0] rd, input bit aerr, input bit illegal,
                     input logic [31:0] xaddr, input logic [2:0] xsize, input bit abort);
    int unsigned t;
    int unsigned c;
    ahb_exp_t a;
    wb_exp_t  w;
    @(posedge clk); #1;
    t = e + 1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_wstrb = strb; wb_dat_w = wd;
    hready = 1'b1; hresp = 1'b0;
    c = illegal ? t : t + aw + dw + 2;
    if (!illegal) begin
      a.addr = xaddr; a.wr = we; a.size = xsize; a.wd = wd; a.at = t + aw;
      q_ahb.push_back(a);
    end
    if (!abort) begin
      w.err = 1'b0;
      if (illegal || aerr) begin
`ifdef WB2AHB_ERR_EN
        w.err = 1'b1;
`else
        if (!we) model_dat_r = 32'h0;
`endif
      end else if (!we) begin
        model_dat_r = rd;
      end
      w.dat = model_dat_r; w.at = c;
      q_wb.push_back(w);
    end
    if (illegal) begin
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      if (abort) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
      for (int i = 0; i < int'(aw); i++) begin
        hready = 1'b0;
        @(posedge clk); #1;
      end
      hready = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < int'(dw); i++) begin
        hready = 1'b0;
        hresp  = aerr && (i == int'(dw) - 1);
        @(posedge clk); #1;
      end
      hready = 1'b1; hresp = aerr; hrdata = rd;
      @(posedge clk); #1;
      hresp = 1'b0; hrdata = 32'h5A5A_5A5A;
    end
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_wstrb = 4'h0;
    wb_adr = 32'h0; wb_dat_w = 32'h0;
    hrdata = 32'h5A5A_5A5A; hready = 1'b1; hresp = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    //   we    adr            strb     wd            aw dw rd            aerr ill  xaddr          xsz     abort
    txn(1'b1, 32'h0000_0100, 4'b1111, 32'hDEADBEEF, 0, 0, 32'h0,        0,   0,   32'h0000_0100, 3'b010, 0);
    txn(1'b0, 32'h0000_0206, 4'b0000, 32'h0,        0, 2, 32'h12345678, 0,   0,   32'h0000_0204, 3'b010, 0);
    txn(1'b1, 32'h1000_0000, 4'b0100, 32'hA5A5A5A5, 0, 0, 32'h0,        0,   0,   32'h1000_0002, 3'b000, 0);
    txn(1'b1, 32'h1000_0000, 4'b1100, 32'h11223344, 0, 0, 32'h0,        0,   0,   32'h1000_0002, 3'b001, 0);
    txn(1'b1, 32'h0000_0040, 4'b0011, 32'h55667788, 1, 0, 32'h0,        0,   0,   32'h0000_0040, 3'b001, 0);
    txn(1'b1, 32'h0000_0040, 4'b1000, 32'h99AABBCC, 0, 1, 32'h0,        0,   0,   32'h0000_0043, 3'b000, 0);
    txn(1'b1, 32'h0000_0052, 4'b0001, 32'h01020304, 0, 0, 32'h0,        0,   0,   32'h0000_0050, 3'b000, 0);
    txn(1'b0, 32'h0000_0080, 4'b1111, 32'h0,        0, 1, 32'hFEEDFACE, 1,   0,   32'h0000_0080, 3'b010, 0);
    txn(1'b1, 32'h0000_0090, 4'b0101, 32'h0BADBEEF, 0, 0, 32'h0,        0,   1,   32'h0,         3'b000, 0);
    txn(1'b1, 32'h0000_0094, 4'b0000, 32'h0BADBEEF, 0, 0, 32'h0,        0,   1,   32'h0,         3'b000, 0);
    txn(1'b1, 32'h0000_0200, 4'b1111, 32'hC0FFEE00, 2, 1, 32'h0,        0,   0,   32'h0000_0200, 3'b010, 1);
    txn(1'b0, 32'h0000_0024, 4'b0000, 32'h0,        0, 0, 32'h600DCAFE, 0,   0,   32'h0000_0024, 3'b010, 0);

    // Reset asserted while a read sits in its data phase.
    begin
      ahb_exp_t a;
      @(posedge clk); #1;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0000_0300; wb_wstrb = 4'h0;
      hready = 1'b1;
      a.addr = 32'h0000_0300; a.wr = 1'b0; a.size = 3'b010; a.wd = 32'h0; a.at = e + 1;
      q_ahb.push_back(a);
      @(posedge clk); #1;
      @(posedge clk); #1;
      hready = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      wb_cyc = 1'b0; wb_stb = 1'b0; hready = 1'b1;
      model_dat_r = 32'h0;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end

    txn(1'b0, 32'h0000_0010, 4'b0000, 32'h0,        0, 0, 32'hCAFEF00D, 0,   0,   32'h0000_0010, 3'b010, 0);
    txn(1'b1, 32'h0000_0014, 4'b0010, 32'h77777777, 0, 0, 32'h0,        0,   0,   32'h0000_0015, 3'b000, 0);

    repeat (2) @(posedge clk);
    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", e);
    $fatal(1, "watchdog expired");
  end

endmodule
